// File: rtl/dms_pll_pkg.sv
// Shared defaults, types and arithmetic helpers for the all-digital
// up/down controller that replaces the charge-pump path of the DMS loop.
package dms_pll_pkg;

    localparam int DEF_CW        = 8;
    localparam int DEF_CTRL_INIT = 128;
    localparam int DEF_STEP      = 1;
    localparam int DEF_DIV_BASE  = 300;
    localparam int DEF_LOCK_CNT  = 16;
    localparam int DEF_LOCK_TOL  = 1;

    typedef logic [DEF_CW-1:0] ctrl_t;

    // Adds a signed delta and clamps the result to [0, max_val].
    function automatic int sat_add_sub(input int cur, input int delta, input int max_val);
        int sum;
        sum = cur + delta;
        if (sum > max_val) return max_val;
        if (sum < 0)       return 0;
        return sum;
    endfunction

endpackage

// File: rtl/dms_sync_edge.sv
// Two-flop synchronizer for an asynchronous PFD pulse, followed by a third
// flop that turns each synchronized rising edge into a one-cycle event.
module dms_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic evt
);

    logic s1;
    logic s2;
    logic s3;

    // NOTE: non-blocking assignments make each flop take its predecessor's
    // pre-edge value, which is what builds the shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt = s2 & ~s3;

endmodule

// File: rtl/dms_updn_ctrl.sv
// Integrates synchronized PFD up/down events into a saturating control word,
// divides clk into the feedback clock, and flags lock when corrections thin out.
module dms_updn_ctrl
    import dms_pll_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int CTRL_INIT = DEF_CTRL_INIT,
    parameter int STEP      = DEF_STEP,
    parameter int DIV_BASE  = DEF_DIV_BASE,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int LOCK_TOL  = DEF_LOCK_TOL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up,
    input  logic          down,
    output logic [CW-1:0] ctrl_word,
    output logic          fbclk,
    output logic          locked
);

    localparam int NW       = $clog2(DIV_BASE + 1);
    localparam int GW       = $clog2(LOCK_CNT + 1);
    localparam int CTRL_MAX = (1 << CW) - 1;

    logic          up_evt;
    logic          dn_evt;
    logic          any_evt;
    logic [CW-1:0] ctrl_next;
    logic [NW-1:0] div_cnt;
    logic [NW-1:0] half_len;
    logic          div_wrap;
    logic          fb_rise;
    logic [1:0]    evt_cnt;
    logic [GW-1:0] good;
    logic [GW-1:0] good_next;

    dms_sync_edge u_sync_up (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (up),
        .evt   (up_evt)
    );

    dms_sync_edge u_sync_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (down),
        .evt   (dn_evt)
    );

    assign any_evt = up_evt | dn_evt;

    // NOTE: the default assignment first guarantees every path drives
    // ctrl_next, so no latch is inferred.
    always_comb begin
        ctrl_next = ctrl_word;
        if (up_evt && !dn_evt)
            ctrl_next = CW'(sat_add_sub(int'(ctrl_word), STEP, CTRL_MAX));
        else if (dn_evt && !up_evt)
            ctrl_next = CW'(sat_add_sub(int'(ctrl_word), -STEP, CTRL_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl_word <= CW'(CTRL_INIT);
        else
            ctrl_word <= ctrl_next;
    end

    // The half-period length reloads only at a toggle, so a control change
    // never shortens the half-period already in progress.
    assign div_wrap = (div_cnt == half_len - NW'(1));
    assign fb_rise  = div_wrap & ~fbclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_len <= NW'(DIV_BASE - CTRL_INIT);
            fbclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            half_len <= NW'(DIV_BASE - int'(ctrl_word));
            fbclk    <= ~fbclk;
        end else begin
            div_cnt  <= div_cnt + NW'(1);
        end
    end

    always_comb begin
        good_next = good;
        if (fb_rise) begin
            if (int'(evt_cnt) <= LOCK_TOL)
                good_next = (good == GW'(LOCK_CNT)) ? good : good + GW'(1);
            else
                good_next = '0;
        end
    end

    // An event landing in the toggle cycle belongs to the new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= 2'd0;
            good    <= '0;
            locked  <= 1'b0;
        end else begin
            if (fb_rise)
                evt_cnt <= {1'b0, any_evt};
            else if (any_evt && evt_cnt != 2'd3)
                evt_cnt <= evt_cnt + 2'd1;
            good   <= good_next;
            locked <= (good_next == GW'(LOCK_CNT));
        end
    end

endmodule

// File: tb/tb_dms_updn_ctrl.sv
// Directed bench for dms_updn_ctrl: an edge-level behavioural model checked
// every cycle, plus hand-computed checkpoints for the key timings.
module tb_dms_updn_ctrl;

    localparam int CTRL_INIT = 128;
    localparam int STEP      = 1;
    localparam int DIV_BASE  = 300;
    localparam int LOCK_CNT  = 16;
    localparam int LOCK_TOL  = 1;
    localparam int CMAX      = 255;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       up    = 1'b0;
    logic       down  = 1'b0;
    logic [7:0] ctrl_word;
    logic       fbclk;
    logic       locked;

    int total = 0;
    int bad   = 0;

    dms_updn_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up),
        .down      (down),
        .ctrl_word (ctrl_word),
        .fbclk     (fbclk),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Model state: uh/dh hold the input as sampled at the last three edges
    // (bit 0 newest); cnt counts edges since the last fbclk toggle.
    typedef struct packed {
        int       ctrl;
        int       half;
        int       cnt;
        int       good;
        int       evts;
        bit       fb;
        bit       lk;
        bit [2:0] uh;
        bit [2:0] dh;
    } model_t;

    model_t m;
    bit     cmp_en = 1'b0;

    function automatic model_t model_reset();
        model_t r;
        r      = '0;
        r.ctrl = CTRL_INIT;
        r.half = DIV_BASE - CTRL_INIT;
        return r;
    endfunction

    // An input high at edge k-2 and low at edge k-3 is an event applied at edge k.
    function automatic model_t model_step(model_t s, logic u, logic d);
        model_t n;
        bit ue, de, rise;
        n    = s;
        ue   = s.uh[1] & ~s.uh[2];
        de   = s.dh[1] & ~s.dh[2];
        n.uh = {s.uh[1:0], bit'(u)};
        n.dh = {s.dh[1:0], bit'(d)};
        rise = 1'b0;
        n.cnt = s.cnt + 1;
        if (n.cnt == s.half) begin
            n.fb   = ~s.fb;
            rise   = n.fb;
            n.cnt  = 0;
            n.half = DIV_BASE - s.ctrl;
        end
        if (rise) begin
            if (s.evts <= LOCK_TOL) n.good = (s.good < LOCK_CNT) ? s.good + 1 : LOCK_CNT;
            else                    n.good = 0;
            n.evts = (ue | de) ? 1 : 0;
        end else if (ue | de) begin
            n.evts = s.evts + 1;
        end
        n.lk = (n.good == LOCK_CNT);
        if (ue && !de)      n.ctrl = (s.ctrl + STEP > CMAX) ? CMAX : s.ctrl + STEP;
        else if (de && !ue) n.ctrl = (s.ctrl - STEP < 0) ? 0 : s.ctrl - STEP;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, up, down);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            total++;
            if ({ctrl_word, fbclk, locked} !== {8'(m.ctrl), m.fb, m.lk}) begin
                bad++;
                $display("FAIL model_cycle t=%0t: got ctrl=%0d fb=%b lock=%b, want ctrl=%0d fb=%b lock=%b",
                         $time, ctrl_word, fbclk, locked, m.ctrl, m.fb, m.lk);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        #1;
        check("reset ctrl_word", 32'(ctrl_word), 128);
        check("reset fbclk", 32'(fbclk), 0);
        check("reset locked", 32'(locked), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic pu, input logic pd);
        @(negedge clk);
        up   = pu;
        down = pd;
        repeat (3) @(negedge clk);
        up   = 1'b0;
        down = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Counts rising clk edges until fbclk changes; returns with n = edges taken.
    task automatic wait_toggle(output int n);
        logic start;
        start = fbclk;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (fbclk !== start) return;
        end
        total++;
        bad++;
        $display("FAIL toggle_timeout: got no fbclk edge in %0d clk, want one", n);
    endtask

    initial begin
        int n;
        int rises;
        int c;

        #2 rst_n = 1'b0;
        #1;
        check("por ctrl_word", 32'(ctrl_word), 128);
        check("por fbclk", 32'(fbclk), 0);
        check("por locked", 32'(locked), 0);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Quiet loop after reset: 172-clk halves, lock on the 16th rise.
        wait_toggle(n);
        check("first rise edges", 32'(n), 172);
        wait_toggle(n);
        check("first fall edges", 32'(n), 172);
        rises = 1;
        while (rises < 16) begin
            wait_toggle(n);
            rises++;
            if (rises == 15) check("locked at rise 15", 32'(locked), 0);
            if (rises == 16) check("locked at rise 16", 32'(locked), 1);
            if (rises < 16) wait_toggle(n);
        end

        // Two corrections in one period drop lock at the next rise.
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("ctrl after two ups", 32'(ctrl_word), 130);
        wait_toggle(n);
        wait_toggle(n);
        check("unlock after 2 events", 32'(locked), 0);
        wait_toggle(n);
        wait_toggle(n);
        check("good restarted", 32'(locked), 0);

        // Simultaneous up/down cancels; a single up lands on the 3rd edge.
        do_reset();
        pulse(1'b1, 1'b1);
        check("simultaneous up/down", 32'(ctrl_word), 128);
        @(negedge clk);
        up = 1'b1;
        @(posedge clk); #1 check("up edge 1", 32'(ctrl_word), 128);
        @(posedge clk); #1 check("up edge 2", 32'(ctrl_word), 128);
        @(posedge clk); #1 check("up edge 3", 32'(ctrl_word), 129);
        @(negedge clk);
        up = 1'b0;
        wait_toggle(n);
        wait_toggle(n);
        check("half after up", 32'(n), 171);

        // Saturation at the top of the range.
        repeat (130) pulse(1'b1, 1'b0);
        check("ctrl saturates high", 32'(ctrl_word), 255);
        wait_toggle(n);
        wait_toggle(n);
        check("half at ctrl 255", 32'(n), 45);

        // Saturation at the bottom of the range.
        do_reset();
        repeat (130) pulse(1'b0, 1'b1);
        check("ctrl saturates low", 32'(ctrl_word), 0);
        wait_toggle(n);
        wait_toggle(n);
        check("half at ctrl 0", 32'(n), 300);

        // Asynchronous reset while locked at ctrl_word = 140.
        do_reset();
        repeat (12) pulse(1'b1, 1'b0);
        check("ctrl after 12 ups", 32'(ctrl_word), 140);
        c = 0;
        while (locked !== 1'b1 && c < 8000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("locked at ctrl 140", 32'(locked), 1);
        repeat (20) @(posedge clk);
        #1;
        check("fbclk high before reset", 32'(fbclk), 1);
        check("ctrl before reset", 32'(ctrl_word), 140);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ctrl_word", 32'(ctrl_word), 128);
        check("async reset fbclk", 32'(fbclk), 0);
        check("async reset locked", 32'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
